mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multi-cycle control FSM for the 16-bit TSC CPU.
- Fetches each instruction, decodes the opcode and function fields, and drives the ALU function code and all datapath enables.
- Sits between instruction/data memory handshakes and the datapath: register file, PC, IR, ALUOut, memory data register.
- Produces the `FUNC_*` codes from opcodes.v that the ALU consumes.

Parameters:
- WORD_SIZE, 16, instruction/data word width.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- instr  input  WORD_SIZE  instruction from IR (valid from ID onward).
- i_ready  input  1  instruction memory ack; data valid this cycle.
- d_ready  input  1  data memory ack; read data valid / write accepted this cycle.
- i_read  output  1  instruction fetch request.
- d_read  output  1  data read request.
- d_write  output  1  data write request.
- ir_write  output  1  latch instr into IR.
- pc_write  output  1  unconditional PC update.
- pc_write_cond  output  1  PC update qualified by ALU bResult.
- pc_src  output  2  0=ALU result, 1=ALUOut, 2=jump target {PC[15:12],imm12}, 3=rs.
- alu_src_a  output  1  0=PC, 1=rs.
- alu_src_b  output  2  0=rt, 1=constant 1, 2=sign-extended imm8, 3=zero-extended imm8.
- alu_func  output  4  ALU function code (`FUNC_*`).
- reg_write  output  1  register file write enable.
- reg_dst  output  2  0=rt, 1=rd, 2=$2.
- mem_to_reg  output  1  write-back source: 1=MDR, 0=ALUOut (PC for JAL/JRL).
- output_port_en  output  1  WWD strobe; latch rs to output port.
- is_halted  output  1  HLT executed.
- num_inst  output  CNT_WIDTH  retired-instruction count.

Behaviour:
- States: IF, ID, EX, MEM, WB, HALT. Outputs are Moore-decoded from state plus IR fields and are held constant during wait cycles.
- Reset (async): state=IF, num_inst=0. While reset_n is low, every output is 0. This applies mid-operation too: a pending d_read/d_write drops in the same cycle. After release, fetch restarts in IF.
- IF: i_read=1; alu_src_a=0, alu_src_b=1, alu_func=FUNC_ADD.
  - i_ready=0: stay in IF.
  - i_ready=1: ir_write=1, pc_write=1, pc_src=0, go to ID.
- ID: ALUOut <= PC + sext(imm8) (alu_src_a=0, alu_src_b=2, FUNC_ADD).
  - JMP: pc_write, pc_src=2, go to IF.
  - JAL: as JMP, plus reg_write, reg_dst=2, mem_to_reg=0, go to IF.
  - JPR: pc_write, pc_src=3, go to IF.
  - JRL: as JPR, plus reg_write to $2, go to IF.
  - HLT: go to HALT.
  - Undefined opcode/func: retired as NOP, go to IF.
  - All others: go to EX.
- EX:
  - R-type ALU ops: alu_src_a=1, alu_src_b=0, alu_func=func[3:0].
  - ADI, LWD, SWD: FUNC_ADD with alu_src_b=2. ORI: FUNC_ORR with alu_src_b=3. LHI: FUNC_LHI with alu_src_b=3.
  - BNE/BEQ/BGZ/BLZ: matching `FUNC_B*`, alu_src_a=1, alu_src_b=0, pc_write_cond=1, pc_src=1, go to IF.
  - WWD: output_port_en=1 for one cycle, go to IF.
  - LWD/SWD: go to MEM. Others: go to WB.
- MEM: LWD holds d_read=1, SWD holds d_write=1 until d_ready=1.
  - LWD, d_ready=1: go to WB.
  - SWD, d_ready=1: go to IF.
- WB: reg_write=1 for exactly one cycle. reg_dst=1 for R-type, 0 for I-type. mem_to_reg=1 only for LWD. Go to IF.
- HALT: is_halted=1 and all other strobes 0. Exits only by reset.
- Retirement: num_inst increments by 1 on the clock edge leaving an instruction's final state (IF is next) and on entry to HALT. It wraps modulo 2^CNT_WIDTH.
- i_ready/d_ready asserted outside their request states are ignored.

Optional Feature:
- Macro: INST_COUNT_EN.
- Defined: num_inst counter as above.
- Undefined: no counter register; num_inst tied to 0.

Test Plan:
- ADD 0xF6C0, i_ready=1 on first IF cycle -> IF,ID,EX,WB (4 cycles); EX alu_func=FUNC_ADD, alu_src_a=1, alu_src_b=0; WB reg_write=1, reg_dst=1; num_inst 0->1.
- LWD 0x7105, d_ready low for 3 MEM cycles -> d_read held 4 cycles; 8 cycles total; WB mem_to_reg=1, reg_dst=0.
- BEQ 0x1001 -> 3 cycles; EX alu_func=FUNC_BEQ, pc_write_cond=1, pc_src=1, reg_write=0 throughout.
- JAL 0xA010 -> 2 cycles; ID pc_write=1, pc_src=2, reg_write=1, reg_dst=2.
- HLT 0xF01D -> is_halted=1 after ID; i_read stays 0 for 10+ cycles; num_inst increments once.
- SWD in MEM with d_ready=0, then reset_n low mid-cycle -> d_write=0 immediately, num_inst=0; after release, i_read=1 in the next cycle.

Source files
------------

// File: rtl/mc_control.sv
// mc_control: multi-cycle control FSM for the 16-bit TSC CPU.
// Sequences IF/ID/EX/MEM/WB/HALT, drives every datapath enable and the ALU
// function code, and handshakes with instruction and data memory.
// Optional build macro: INST_COUNT_EN enables the retired-instruction
// counter on num_inst; without it num_inst is tied to zero.
module mc_control #(
   parameter int WORD_SIZE = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WORD_SIZE-1:0] instr,
   input  logic                 i_ready,
   input  logic                 d_ready,
   output logic                 i_read,
   output logic                 d_read,
   output logic                 d_write,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 pc_write_cond,
   output logic [1:0]           pc_src,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [3:0]           alu_func,
   output logic                 reg_write,
   output logic [1:0]           reg_dst,
   output logic                 mem_to_reg,
   output logic                 output_port_en,
   output logic                 is_halted,
   output logic [CNT_WIDTH-1:0] num_inst
);

   // Opcode field values
   localparam logic [3:0] OP_BNE   = 4'd0;
   localparam logic [3:0] OP_BEQ   = 4'd1;
   localparam logic [3:0] OP_BGZ   = 4'd2;
   localparam logic [3:0] OP_BLZ   = 4'd3;
   localparam logic [3:0] OP_ADI   = 4'd4;
   localparam logic [3:0] OP_ORI   = 4'd5;
   localparam logic [3:0] OP_LHI   = 4'd6;
   localparam logic [3:0] OP_LWD   = 4'd7;
   localparam logic [3:0] OP_SWD   = 4'd8;
   localparam logic [3:0] OP_JMP   = 4'd9;
   localparam logic [3:0] OP_JAL   = 4'd10;
   localparam logic [3:0] OP_RTYPE = 4'd15;

   // Function field values for opcode 15 control instructions
   localparam logic [5:0] FN_ALU_MAX = 6'd7;
   localparam logic [5:0] FN_JPR     = 6'd25;
   localparam logic [5:0] FN_JRL     = 6'd26;
   localparam logic [5:0] FN_WWD     = 6'd28;
   localparam logic [5:0] FN_HLT     = 6'd29;

   // ALU function codes consumed by the datapath ALU
   localparam logic [3:0] FUNC_ADD = 4'd0;
   localparam logic [3:0] FUNC_ORR = 4'd3;
   localparam logic [3:0] FUNC_LHI = 4'd8;
   localparam logic [3:0] FUNC_BNE = 4'd9;
   localparam logic [3:0] FUNC_BEQ = 4'd10;
   localparam logic [3:0] FUNC_BGZ = 4'd11;
   localparam logic [3:0] FUNC_BLZ = 4'd12;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   state_t state;
   state_t state_next;

   logic [3:0] op;
   logic [5:0] func;
   logic [5:0] unused_fields;

   assign op            = instr[15:12];
   assign func          = instr[5:0];
   assign unused_fields = instr[11:6];

   logic is_ralu, is_adi, is_ori, is_lhi, is_lwd, is_swd, is_branch;
   logic is_jmp, is_jal, is_jpr, is_jrl, is_wwd, is_hlt, is_undef;

   // Classify the instruction held in IR
   always_comb begin
      is_ralu   = (op == OP_RTYPE) && (func <= FN_ALU_MAX);
      is_adi    = (op == OP_ADI);
      is_ori    = (op == OP_ORI);
      is_lhi    = (op == OP_LHI);
      is_lwd    = (op == OP_LWD);
      is_swd    = (op == OP_SWD);
      is_branch = (op == OP_BNE) || (op == OP_BEQ) || (op == OP_BGZ) || (op == OP_BLZ);
      is_jmp    = (op == OP_JMP);
      is_jal    = (op == OP_JAL);
      is_jpr    = (op == OP_RTYPE) && (func == FN_JPR);
      is_jrl    = (op == OP_RTYPE) && (func == FN_JRL);
      is_wwd    = (op == OP_RTYPE) && (func == FN_WWD);
      is_hlt    = (op == OP_RTYPE) && (func == FN_HLT);
      is_undef  = !(is_ralu || is_adi || is_ori || is_lhi || is_lwd || is_swd ||
                    is_branch || is_jmp || is_jal || is_jpr || is_jrl ||
                    is_wwd || is_hlt);
   end

   // Next-state selection; instructions that finish early return straight to IF
   always_comb begin
      state_next = state;
      case (state)
         S_IF: begin
            if (i_ready) state_next = S_ID;
         end
         S_ID: begin
            if (is_hlt)
               state_next = S_HALT;
            else if (is_jmp || is_jal || is_jpr || is_jrl || is_undef)
               state_next = S_IF;
            else
               state_next = S_EX;
         end
         S_EX: begin
            if (is_branch || is_wwd)
               state_next = S_IF;
            else if (is_lwd || is_swd)
               state_next = S_MEM;
            else
               state_next = S_WB;
         end
         S_MEM: begin
            if (d_ready) state_next = is_lwd ? S_WB : S_IF;
         end
         S_WB:    state_next = S_IF;
         S_HALT:  state_next = S_HALT;
         default: state_next = S_IF;
      endcase
   end

   // State register; HALT is left only through reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IF;
      else          state <= state_next;
   end

`ifdef INST_COUNT_EN
   logic                 retire;
   logic [CNT_WIDTH-1:0] inst_cnt;

   assign retire = (state != S_IF) && (state != S_HALT) &&
                   ((state_next == S_IF) || (state_next == S_HALT));

   // Retired-instruction counter, wraps naturally at its width
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    inst_cnt <= '0;
      else if (retire) inst_cnt <= inst_cnt + CNT_WIDTH'(1);
   end

   assign num_inst = inst_cnt;
`else
   assign num_inst = '0;
`endif

   logic       i_read_d, d_read_d, d_write_d, ir_write_d, pc_write_d;
   logic       pc_write_cond_d, alu_src_a_d, reg_write_d, mem_to_reg_d;
   logic       output_port_en_d, is_halted_d;
   logic [1:0] pc_src_d, alu_src_b_d, reg_dst_d;
   logic [3:0] alu_func_d;

   // Output decode from state and IR fields; IR only becomes valid in ID, so
   // these cannot be registered a cycle early. IF qualifies the IR/PC latch
   // with the fetch ack.
   always_comb begin
      i_read_d         = 1'b0;
      d_read_d         = 1'b0;
      d_write_d        = 1'b0;
      ir_write_d       = 1'b0;
      pc_write_d       = 1'b0;
      pc_write_cond_d  = 1'b0;
      pc_src_d         = 2'd0;
      alu_src_a_d      = 1'b0;
      alu_src_b_d      = 2'd0;
      alu_func_d       = FUNC_ADD;
      reg_write_d      = 1'b0;
      reg_dst_d        = 2'd0;
      mem_to_reg_d     = 1'b0;
      output_port_en_d = 1'b0;
      is_halted_d      = 1'b0;
      case (state)
         S_IF: begin
            i_read_d    = 1'b1;
            alu_src_b_d = 2'd1;
            if (i_ready) begin
               ir_write_d = 1'b1;
               pc_write_d = 1'b1;
            end
         end
         S_ID: begin
            // Precompute PC + sext(imm8) into ALUOut for a possible branch
            alu_src_b_d = 2'd2;
            if (is_jmp || is_jal) begin
               pc_write_d = 1'b1;
               pc_src_d   = 2'd2;
            end
            if (is_jpr || is_jrl) begin
               pc_write_d = 1'b1;
               pc_src_d   = 2'd3;
            end
            if (is_jal || is_jrl) begin
               reg_write_d = 1'b1;
               reg_dst_d   = 2'd2;
            end
         end
         S_EX: begin
            if (is_ralu) begin
               alu_src_a_d = 1'b1;
               alu_func_d  = func[3:0];
            end
            if (is_adi || is_lwd || is_swd) begin
               alu_src_a_d = 1'b1;
               alu_src_b_d = 2'd2;
            end
            if (is_ori) begin
               alu_src_a_d = 1'b1;
               alu_src_b_d = 2'd3;
               alu_func_d  = FUNC_ORR;
            end
            if (is_lhi) begin
               alu_src_a_d = 1'b1;
               alu_src_b_d = 2'd3;
               alu_func_d  = FUNC_LHI;
            end
            if (is_branch) begin
               alu_src_a_d     = 1'b1;
               pc_write_cond_d = 1'b1;
               pc_src_d        = 2'd1;
               case (op)
                  OP_BNE:  alu_func_d = FUNC_BNE;
                  OP_BEQ:  alu_func_d = FUNC_BEQ;
                  OP_BGZ:  alu_func_d = FUNC_BGZ;
                  default: alu_func_d = FUNC_BLZ;
               endcase
            end
            if (is_wwd) output_port_en_d = 1'b1;
         end
         S_MEM: begin
            d_read_d  = is_lwd;
            d_write_d = is_swd;
         end
         S_WB: begin
            reg_write_d  = 1'b1;
            reg_dst_d    = is_ralu ? 2'd1 : 2'd0;
            mem_to_reg_d = is_lwd;
         end
         S_HALT: begin
            is_halted_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset forces every output low immediately, including in-flight requests
   assign i_read         = reset_n & i_read_d;
   assign d_read         = reset_n & d_read_d;
   assign d_write        = reset_n & d_write_d;
   assign ir_write       = reset_n & ir_write_d;
   assign pc_write       = reset_n & pc_write_d;
   assign pc_write_cond  = reset_n & pc_write_cond_d;
   assign pc_src         = reset_n ? pc_src_d    : 2'd0;
   assign alu_src_a      = reset_n & alu_src_a_d;
   assign alu_src_b      = reset_n ? alu_src_b_d : 2'd0;
   assign alu_func       = reset_n ? alu_func_d  : 4'd0;
   assign reg_write      = reset_n & reg_write_d;
   assign reg_dst        = reset_n ? reg_dst_d   : 2'd0;
   assign mem_to_reg     = reset_n & mem_to_reg_d;
   assign output_port_en = reset_n & output_port_en_d;
   assign is_halted      = reset_n & is_halted_d;

endmodule

// File: tb/tb_mc_control.sv
// Testbench for mc_control: directed cycle table, hand-written multi-cycle
// sequences, and random instruction streams checked against an
// instruction-level model that expands each instruction into its cycles.
module tb_mc_control;

   localparam int CW = 16;
`ifdef INST_COUNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   localparam logic [3:0] FADD = 4'd0, FORR = 4'd3, FLHI = 4'd8, FBNE = 4'd9, FBEQ = 4'd10;

   localparam int C_R = 0, C_ADI = 1, C_ORI = 2, C_LHI = 3, C_LWD = 4, C_SWD = 5, C_BR = 6;
   localparam int C_JMP = 7, C_JAL = 8, C_JPR = 9, C_JRL = 10, C_WWD = 11, C_HLT = 12, C_UND = 13;

   typedef struct packed {
      logic       i_read, d_read, d_write, ir_write, pc_write, pc_write_cond;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_func;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic       mem_to_reg, output_port_en, is_halted;
   } outs_t;

   typedef struct {
      logic [15:0] ins;
      logic        ir;
      logic        dr;
      outs_t       exp;
      int          cnt;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [15:0]   instr;
   logic          i_ready, d_ready;
   logic          i_read, d_read, d_write, ir_write, pc_write, pc_write_cond;
   logic [1:0]    pc_src, alu_src_b, reg_dst;
   logic          alu_src_a, reg_write, mem_to_reg, output_port_en, is_halted;
   logic [3:0]    alu_func;
   logic [CW-1:0] num_inst;

   outs_t act;
   assign act = {i_read, d_read, d_write, ir_write, pc_write, pc_write_cond, pc_src,
                 alu_src_a, alu_src_b, alu_func, reg_write, reg_dst, mem_to_reg,
                 output_port_en, is_halted};

   mc_control #(.WORD_SIZE(16), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset_n(reset_n), .instr(instr), .i_ready(i_ready), .d_ready(d_ready),
      .i_read(i_read), .d_read(d_read), .d_write(d_write), .ir_write(ir_write),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_func(alu_func),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .output_port_en(output_port_en), .is_halted(is_halted), .num_inst(num_inst)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int model_cnt = 0;
   int cyc = 0;
   int dread_n = 0;
   logic [15:0] ir_q = 16'h0000;

   function automatic logic [CW-1:0] exp_cnt();
      return CNT_ON ? model_cnt[CW-1:0] : '0;
   endfunction

   task automatic check_outs(input string nm, input outs_t e);
      n_chk++;
      if (act === e) n_pass++;
      else $display("FAIL %s: outputs got %h expected %h", nm, act, e);
   endtask

   task automatic check_val(input string nm, input int got, input int e);
      n_chk++;
      if (got == e) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, got, e);
   endtask

   // Instruction class straight from the ISA encoding
   function automatic int cls(input logic [15:0] ins);
      logic [5:0] f;
      f = ins[5:0];
      case (ins[15:12])
         4'd0, 4'd1, 4'd2, 4'd3: return C_BR;
         4'd4:  return C_ADI;
         4'd5:  return C_ORI;
         4'd6:  return C_LHI;
         4'd7:  return C_LWD;
         4'd8:  return C_SWD;
         4'd9:  return C_JMP;
         4'd10: return C_JAL;
         4'd15: begin
            if (f < 6'd8)  return C_R;
            if (f == 6'd25) return C_JPR;
            if (f == 6'd26) return C_JRL;
            if (f == 6'd28) return C_WWD;
            if (f == 6'd29) return C_HLT;
            return C_UND;
         end
         default: return C_UND;
      endcase
   endfunction

   function automatic outs_t o_if(input bit ack);
      outs_t o = '0;
      o.i_read = 1'b1; o.alu_src_b = 2'd1; o.alu_func = FADD;
      o.ir_write = ack; o.pc_write = ack;
      return o;
   endfunction

   function automatic outs_t o_id(input int c);
      outs_t o = '0;
      o.alu_src_b = 2'd2;
      if (c == C_JMP || c == C_JAL) begin o.pc_write = 1'b1; o.pc_src = 2'd2; end
      if (c == C_JPR || c == C_JRL) begin o.pc_write = 1'b1; o.pc_src = 2'd3; end
      if (c == C_JAL || c == C_JRL) begin o.reg_write = 1'b1; o.reg_dst = 2'd2; end
      return o;
   endfunction

   function automatic outs_t o_ex(input int c, input logic [15:0] ins);
      outs_t o = '0;
      case (c)
         C_R:   begin o.alu_src_a = 1'b1; o.alu_func = ins[3:0]; end
         C_ADI, C_LWD, C_SWD: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; end
         C_ORI: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd3; o.alu_func = FORR; end
         C_LHI: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd3; o.alu_func = FLHI; end
         C_BR:  begin
            o.alu_src_a = 1'b1; o.pc_write_cond = 1'b1; o.pc_src = 2'd1;
            o.alu_func = FBNE + {2'b00, ins[13:12]};
         end
         C_WWD: o.output_port_en = 1'b1;
         default: ;
      endcase
      return o;
   endfunction

   function automatic outs_t o_mem(input int c);
      outs_t o = '0;
      o.d_read = (c == C_LWD); o.d_write = (c == C_SWD);
      return o;
   endfunction

   function automatic outs_t o_wb(input int c);
      outs_t o = '0;
      o.reg_write = 1'b1; o.reg_dst = (c == C_R) ? 2'd1 : 2'd0; o.mem_to_reg = (c == C_LWD);
      return o;
   endfunction

   function automatic outs_t o_halt();
      outs_t o = '0;
      o.is_halted = 1'b1;
      return o;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock cycle: drive inputs after the falling edge, then compare
   task automatic cycle(input logic [15:0] ins, input logic ir, input logic dr,
                        input outs_t e, input string nm);
      @(negedge clk);
      instr = ins; i_ready = ir; d_ready = dr;
      #1;
      cyc++;
      if (act.d_read) dread_n++;
      check_outs(nm, e);
      check_val({nm, "_cnt"}, int'(num_inst), int'(exp_cnt()));
   endtask

   // Expand one non-halting instruction into its expected cycles
   task automatic run_instr(input logic [15:0] ins, input int iw, input int dw);
      int c;
      c = cls(ins);
      for (int k = 0; k < iw; k++) cycle(ir_q, 1'b0, rb(), o_if(1'b0), "if_wait");
      cycle(ir_q, 1'b1, rb(), o_if(1'b1), "if_ack");
      ir_q = ins;
      cycle(ins, rb(), rb(), o_id(c), "id");
      if (c == C_JMP || c == C_JAL || c == C_JPR || c == C_JRL || c == C_UND) begin
         model_cnt++;
         return;
      end
      cycle(ins, rb(), rb(), o_ex(c, ins), "ex");
      if (c == C_BR || c == C_WWD) begin
         model_cnt++;
         return;
      end
      if (c == C_LWD || c == C_SWD) begin
         for (int k = 0; k < dw; k++) cycle(ins, rb(), 1'b0, o_mem(c), "mem_wait");
         cycle(ins, rb(), 1'b1, o_mem(c), "mem_ack");
         if (c == C_SWD) begin
            model_cnt++;
            return;
         end
      end
      cycle(ins, rb(), rb(), o_wb(c), "wb");
      model_cnt++;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #2;
      reset_n = 1'b0; i_ready = 1'b0; d_ready = 1'b0;
      #1;
      check_outs("rst_outs", '0);
      check_val("rst_cnt", int'(num_inst), 0);
      @(negedge clk);
      #1;
      check_outs("rst_hold_outs", '0);
      reset_n = 1'b1;
      model_cnt = 0;
   endtask

   function automatic vec_t mkv(input logic [15:0] ins, input logic ir, input logic dr,
                                input outs_t e, input int cnt);
      vec_t v;
      v.ins = ins; v.ir = ir; v.dr = dr; v.exp = e; v.cnt = cnt;
      return v;
   endfunction

   initial begin
      vec_t vt[11];
      logic [15:0] ins;
      int c0;

      // Directed cycle table: ADD, BEQ, JAL, then ignored acks while fetching
      vt[0]  = mkv(16'h0000, 1'b1, 1'b0, '{i_read:1'b1, ir_write:1'b1, pc_write:1'b1, alu_src_b:2'd1, default:0}, 0);
      vt[1]  = mkv(16'hF6C0, 1'b0, 1'b0, '{alu_src_b:2'd2, default:0}, 0);
      vt[2]  = mkv(16'hF6C0, 1'b0, 1'b0, '{alu_src_a:1'b1, alu_func:FADD, default:0}, 0);
      vt[3]  = mkv(16'hF6C0, 1'b1, 1'b1, '{reg_write:1'b1, reg_dst:2'd1, default:0}, 0);
      vt[4]  = mkv(16'hF6C0, 1'b1, 1'b0, '{i_read:1'b1, ir_write:1'b1, pc_write:1'b1, alu_src_b:2'd1, default:0}, 1);
      vt[5]  = mkv(16'h1001, 1'b0, 1'b0, '{alu_src_b:2'd2, default:0}, 1);
      vt[6]  = mkv(16'h1001, 1'b1, 1'b1, '{alu_src_a:1'b1, alu_func:FBEQ, pc_write_cond:1'b1, pc_src:2'd1, default:0}, 1);
      vt[7]  = mkv(16'h1001, 1'b1, 1'b0, '{i_read:1'b1, ir_write:1'b1, pc_write:1'b1, alu_src_b:2'd1, default:0}, 2);
      vt[8]  = mkv(16'hA010, 1'b0, 1'b0, '{pc_write:1'b1, pc_src:2'd2, reg_write:1'b1, reg_dst:2'd2, alu_src_b:2'd2, default:0}, 2);
      vt[9]  = mkv(16'hA010, 1'b0, 1'b0, '{i_read:1'b1, alu_src_b:2'd1, default:0}, 3);
      vt[10] = mkv(16'hA010, 1'b0, 1'b1, '{i_read:1'b1, alu_src_b:2'd1, default:0}, 3);

      reset_n = 1'b1; instr = 16'h0000; i_ready = 1'b0; d_ready = 1'b0;
      #2 reset_n = 1'b0;
      @(negedge clk);
      #1;
      check_outs("init_rst_outs", '0);
      check_val("init_rst_cnt", int'(num_inst), 0);
      reset_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         instr = vt[i].ins; i_ready = vt[i].ir; d_ready = vt[i].dr;
         #1;
         check_outs($sformatf("tbl%0d", i), vt[i].exp);
         check_val($sformatf("tbl%0d_cnt", i), int'(num_inst), CNT_ON ? vt[i].cnt : 0);
      end
      ir_q = 16'hA010;
      model_cnt = 3;

      // LWD with three data wait cycles
      c0 = cyc; dread_n = 0;
      run_instr(16'h7105, 0, 3);
      check_val("lwd_cycles", cyc - c0, 8);
      check_val("lwd_dread_cycles", dread_n, 4);

      // Random instruction stream (no HLT)
      for (int n = 0; n < 150; n++) begin
         ins = 16'($urandom_range(0, 65535));
         if (cls(ins) == C_HLT) ins = ins ^ 16'h0001;
         run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3));
      end

      // SWD stalled in MEM, then reset asserted mid-cycle
      ins = 16'h8205;
      cycle(ir_q, 1'b1, 1'b0, o_if(1'b1), "swd_if");
      ir_q = ins;
      cycle(ins, 1'b0, 1'b0, o_id(C_SWD), "swd_id");
      cycle(ins, 1'b0, 1'b0, o_ex(C_SWD, ins), "swd_ex");
      cycle(ins, 1'b0, 1'b0, o_mem(C_SWD), "swd_mem");
      #2;
      reset_n = 1'b0;
      #1;
      check_outs("swd_rst_outs", '0);
      check_val("swd_rst_cnt", int'(num_inst), 0);
      @(negedge clk);
      #1;
      check_outs("swd_rst_hold", '0);
      reset_n = 1'b1;
      model_cnt = 0;
      #1;
      check_outs("post_rst_fetch", o_if(1'b0));

      run_instr(16'hF6C0, 1, 0);
      run_instr(16'h5123, 0, 0);

      // HLT: halts after ID, counted once, fetch stays off
      ins = 16'hF01D;
      cycle(ir_q, 1'b1, 1'b0, o_if(1'b1), "hlt_if");
      ir_q = ins;
      cycle(ins, 1'b0, 1'b0, o_id(C_HLT), "hlt_id");
      model_cnt++;
      for (int k = 0; k < 12; k++) cycle(ins, rb(), rb(), o_halt(), "halted");

      // Restart after reset
      apply_reset();
      run_instr(16'hF6C0, 0, 0);
      run_instr(16'h7105, 1, 1);
      cycle(ir_q, 1'b0, 1'b0, o_if(1'b0), "final_if");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
